mem_access_ctrl: RTL

Multi-cycle data-memory access sequencer between the CPU datapath and a word-wide, variable-latency data memory. It takes the load/store controls the control unit decodes (memRead, memWrite, memDataSize, memBitExt) and runs the memory handshake. Sub-word loads are done by lane extraction with sign or zero extension. Sub-word stores are done by read-modify-write, because the memory has no byte enables. The CPU is stalled until the access completes, errors, or times out.

---
 rtl/mem_access_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences CPU loads and stores onto a word-wide memory
// with variable latency.
//
// Sub-word loads select one lane of the word and then sign-extend or
// zero-extend it. Sub-word stores use read-modify-write, because the memory
// has no byte enables. The CPU stays stalled until the access completes,
// is rejected as illegal, or times out.
//
// Ports
//   clk_i, rst_i        clock and asynchronous active-high reset
//   memRead_i/Write_i   load and store requests, held stable by the CPU while stalled
//   memDataSize_i       0 = word, 1 = half, 2 = byte, 3 = illegal
//   memBitExt_i         load extension: 0 = sign, 1 = zero
//   addr_i, wdata_i     byte address and store data
//   stall_o             freezes the pipeline while an access is in flight
//   rdata_o             extended load result, valid in the DONE cycle
//   access_err_o        pulses in DONE for a misaligned or illegal request
//   bus_err_o           pulses in DONE when the memory times out
//   mem_*               word-wide memory handshake
//
// state     | meaning
// IDLE      | waiting for a request; latch request and check legality
// READ      | load phase; wait for mem_ready_i
// WRITE     | word store phase; wait for mem_ready_i
// RMW_READ  | read the old word for a sub-word store
// RMW_WRITE | write the merged word
// DONE      | release stall for one cycle; error pulses appear here
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [1:0]  memDataSize_i,
  input  logic        memBitExt_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        access_err_o,
  output logic        bus_err_o,
  output logic [29:0] mem_addr_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        ext_q, ext_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access_err_q, access_err_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic req, illegal, in_phase, tmo_hit;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] ln, input logic zx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    r = w;
    if (sz == SZ_HALF)      r = {{16{h[15] & ~zx}}, h};
    else if (sz == SZ_BYTE) r = {{24{b[7] & ~zx}}, b};
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = w;
    if (sz == SZ_HALF) begin
      if (ln[1]) r[31:16] = d;
      else       r[15:0]  = d;
    end else begin
      case (ln)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  assign req      = memRead_i | memWrite_i;
  assign stall_o  = req & (state_q != DONE);
  assign in_phase = (state_q == READ) || (state_q == WRITE) ||
                    (state_q == RMW_READ) || (state_q == RMW_WRITE);
  assign tmo_hit  = (tmo_cnt_q == TMO_LAST) && !mem_ready_i;

  assign illegal = (memRead_i & memWrite_i) ||
                   (memDataSize_i == SZ_ILL) ||
                   ((memDataSize_i == SZ_WORD) && (addr_i[1:0] != 2'b00)) ||
                   ((memDataSize_i == SZ_HALF) && addr_i[0]);

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    ext_d        = ext_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    access_err_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          mem_addr_d = addr_i[31:2];
          size_d     = memDataSize_i;
          ext_d      = memBitExt_i;
          lane_d     = addr_i[1:0];
          wdata_d    = wdata_i[15:0];
          if (illegal) begin
            state_d      = DONE;
            access_err_d = 1'b1;
            rdata_d      = '0;
          end else if (memRead_i) begin
            state_d = READ;
          end else if (memDataSize_i == SZ_WORD) begin
            state_d     = WRITE;
            mem_wdata_d = wdata_i;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      READ: begin
        if (mem_ready_i) begin
          rdata_d = load_extend(mem_rdata_i, size_q, lane_q, ext_q);
          state_d = DONE;
        end
      end
      RMW_READ: begin
        if (mem_ready_i) begin
          mem_wdata_d = store_merge(mem_rdata_i, wdata_q, size_q, lane_q);
          state_d     = RMW_WRITE;
        end
      end
      WRITE, RMW_WRITE: begin
        if (mem_ready_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A timeout abandons the phase. mem_ready_i in the same cycle takes
    // priority because tmo_hit already requires it to be low.
    if (in_phase && tmo_hit) begin
      state_d   = DONE;
      bus_err_d = 1'b1;
      rdata_d   = '0;
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q)            tmo_cnt_d = '0;
    else if (in_phase && !mem_ready_i) tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      size_q       <= SZ_WORD;
      ext_q        <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      ext_q        <= ext_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      access_err_q <= access_err_d;
      bus_err_q    <= bus_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // The enable and write strobe come only from the state register, so they
  // do not glitch and they drop as soon as reset is asserted.
  assign mem_en_o     = in_phase;
  assign mem_we_o     = (state_q == WRITE) || (state_q == RMW_WRITE);
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign rdata_o      = rdata_q;
  assign access_err_o = access_err_q;
  assign bus_err_o    = bus_err_q;

endmodule
